// File: rtl/pipeline_divider_pkg.sv
// Shared CPU definitions for the multi-cycle divider: FSM encoding, iteration
// count and the divide-by-zero quotient.
package pipeline_divider_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITER  = DIV_WIDTH;

    // MIPS leaves div-by-zero undefined; all-ones matches the usual soft model.
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_Q = '1;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_SIGN = 2'd2
    } div_state_e;

endpackage

// File: rtl/pipeline_divider_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial
// subtract the divisor, and record the quotient bit.
import pipeline_divider_pkg::*;

module div_step #(
    parameter int WIDTH = DIV_ITER
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] dq,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] dq_next
);

    logic [WIDTH:0] shifted;
    logic           fits;

    always_comb begin
        shifted  = {rem, dq[WIDTH-1]};
        fits     = (shifted >= {1'b0, dvs});
        rem_next = fits ? WIDTH'(shifted - {1'b0, dvs}) : shifted[WIDTH-1:0];
        dq_next  = {dq[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/pipeline_divider.sv
// Execute-stage divider for div/divu: WIDTH restoring iterations plus one sign
// fix-up cycle, producing q (LO) and r (HI) with a one-cycle done pulse.
//
//   state    | meaning
//   ---------+------------------------------------------------------
//   DIV_IDLE | waiting for start; q/r hold the last result
//   DIV_CALC | one quotient bit per cycle, MSB first
//   DIV_SIGN | apply operand signs / div-by-zero override, write q/r
import pipeline_divider_pkg::*;

module pipeline_divider #(
    parameter int WIDTH = DIV_ITER
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sign,
    input  logic             cancel,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    div_state_e       state, state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dq, rem, dvs, raw_dvd;
    logic [WIDTH-1:0] dq_step, rem_step;
    logic [WIDTH-1:0] q_fin, r_fin;
    logic             neg_q, neg_r, div_zero;
    logic             a_neg, b_neg;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .dq       (dq),
        .dvs      (dvs),
        .rem_next (rem_step),
        .dq_next  (dq_step)
    );

    assign a_neg = sign & dividend[WIDTH-1];
    assign b_neg = sign & divisor[WIDTH-1];
    assign busy  = (state != DIV_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= DIV_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            DIV_IDLE: if (start && !cancel) state_next = DIV_CALC;
            DIV_CALC: begin
                if (cancel)                        state_next = DIV_IDLE;
                else if (cnt == CW'(WIDTH - 1))    state_next = DIV_SIGN;
            end
            DIV_SIGN: state_next = DIV_IDLE;
            default:  state_next = DIV_IDLE;
        endcase
    end

    // -2^31 / -1 needs no special case: |a|/|b| = 0x80000000 with equal signs.
    always_comb begin
        q_fin = neg_q ? -dq  : dq;
        r_fin = neg_r ? -rem : rem;
        if (div_zero) begin
            q_fin = WIDTH'(DIV_ZERO_Q);
            r_fin = raw_dvd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q        <= '0;
            r        <= '0;
            done     <= 1'b0;
            cnt      <= '0;
            dq       <= '0;
            rem      <= '0;
            dvs      <= '0;
            raw_dvd  <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                DIV_IDLE: begin
                    if (start && !cancel) begin
                        dq       <= a_neg ? -dividend : dividend;
                        dvs      <= b_neg ? -divisor  : divisor;
                        rem      <= '0;
                        cnt      <= '0;
                        raw_dvd  <= dividend;
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= a_neg;
                        div_zero <= (divisor == '0);
                    end
                end
                DIV_CALC: begin
                    if (!cancel) begin
                        dq  <= dq_step;
                        rem <= rem_step;
                        cnt <= cnt + CW'(1);
                    end
                end
                DIV_SIGN: begin
                    if (!cancel) begin
                        q    <= q_fin;
                        r    <= r_fin;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
